uart_tx_sched: RTL and testbench

Shares the single UART transmit line between two byte producers and sequences each frame on the baud-rate generator's `txclk` tick. It sits between the `brg` divider, whose `txclk` is a one-`clk_in`-cycle pulse every TX_DIV cycles, and the `tx` pin. It performs round-robin arbitration, a valid/ready byte handshake, and start/data/stop framing, LSB first.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_sched_rr_arb2.sv | 19 +
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   tx_state_t       : transmit sequencer states
//   UART_IDLE_LEVEL  : line level for idle and stop bits
//   UART_START_LEVEL : line level for the start bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   req_valid[1:0] : request lines
//   last           : index of the most recently granted requester (owned by parent)
//   grant[1:0]     : one-hot grant, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    // On contention the requester that did not win last time goes first.
    if (req_valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmit line between two byte producers and frames each
// byte (start, DATA_BITS data LSB first, STOP_BITS stop) on the txclk baud tick.
//   clk_in          : system clock
//   reset_n         : asynchronous active-low reset
//   txclk           : one-cycle baud tick from the divider
//   req_valid[1:0]  : requester i has a byte
//   req_data0/1     : requester bytes
//   req_ready[1:0]  : combinational grant strobe, only while idle
//   tx              : registered serial line, idles high
//   busy            : high from acceptance until frame completion
//   owner           : requester of the frame in flight / last granted
//   tx_done         : one-cycle pulse at frame completion
//
// state | meaning
// IDLE  | arbitrate, accept a byte on handshake
// ARMED | byte latched, waiting for the tick that starts the start bit
// START | start bit on the line
// DATA  | data bits on the line, bitcnt = bits already sent
// STOP  | stop bit(s) on the line, stopcnt = stop bits already started
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 txclk,
  input  logic [1:0]           req_valid,
  input  logic [DATA_BITS-1:0] req_data0,
  input  logic [DATA_BITS-1:0] req_data1,
  output logic [1:0]           req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 owner,
  output logic                 tx_done
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS);

  tx_state_t            state, state_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [3:0]           bitcnt, bitcnt_nx;
  logic [3:0]           stopcnt, stopcnt_nx;
  logic                 last, last_nx;
  logic                 owner_nx, busy_nx, tx_nx, tx_done_nx;
  logic [1:0]           grant;
  logic                 handshake;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant)
  );

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign handshake = |(req_valid & req_ready);

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bitcnt_nx  = bitcnt;
    stopcnt_nx = stopcnt;
    last_nx    = last;
    owner_nx   = owner;
    busy_nx    = busy;
    tx_nx      = tx;
    tx_done_nx = 1'b0;

    case (state)
      IDLE: begin
        // A tick in this cycle is deliberately ignored; framing waits in ARMED.
        if (handshake) begin
          shreg_nx   = grant[1] ? req_data1 : req_data0;
          owner_nx   = grant[1];
          last_nx    = grant[1];
          busy_nx    = 1'b1;
          bitcnt_nx  = 4'd0;
          stopcnt_nx = 4'd0;
          state_nx   = ARMED;
        end
      end
      ARMED: begin
        if (txclk) begin
          tx_nx    = UART_START_LEVEL;
          state_nx = START;
        end
      end
      START: begin
        if (txclk) begin
          tx_nx     = shreg[0];
          shreg_nx  = shreg >> 1;
          bitcnt_nx = 4'd1;
          state_nx  = DATA;
        end
      end
      DATA: begin
        if (txclk) begin
          if (bitcnt == LAST_DATA) begin
            tx_nx      = UART_IDLE_LEVEL;
            stopcnt_nx = 4'd1;
            state_nx   = STOP;
          end else begin
            tx_nx     = shreg[0];
            shreg_nx  = shreg >> 1;
            bitcnt_nx = bitcnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (txclk) begin
          if (stopcnt == LAST_STOP) begin
            busy_nx    = 1'b0;
            tx_done_nx = 1'b1;
            state_nx   = IDLE;
          end else begin
            stopcnt_nx = stopcnt + 4'd1;
          end
        end
      end
      default: begin
        tx_nx    = UART_IDLE_LEVEL;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= 4'd0;
      stopcnt <= 4'd0;
      last    <= 1'b1;
      owner   <= 1'b0;
      busy    <= 1'b0;
      tx      <= UART_IDLE_LEVEL;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bitcnt  <= bitcnt_nx;
      stopcnt <= stopcnt_nx;
      last    <= last_nx;
      owner   <= owner_nx;
      busy    <= busy_nx;
      tx      <= tx_nx;
      tx_done <= tx_done_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: instance 0 uses one stop bit, instance 1 two.
// A transaction-level model predicts every output each cycle; directed
// scenarios additionally pin decoded frames against literal values.
module tb_uart_tx_sched;

  localparam int D = 8;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       txclk = 1'b0;
  logic [1:0] vld [2];
  logic [7:0] dat0 [2];
  logic [7:0] dat1 [2];
  logic [1:0] rdy_o [2];
  logic       tx_o [2];
  logic       busy_o [2];
  logic       owner_o [2];
  logic       done_o [2];

  always #5 clk_in = ~clk_in;

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1)) u1 (
    .clk_in(clk_in), .reset_n(reset_n), .txclk(txclk),
    .req_valid(vld[0]), .req_data0(dat0[0]), .req_data1(dat1[0]),
    .req_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]),
    .owner(owner_o[0]), .tx_done(done_o[0])
  );

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(2)) u2 (
    .clk_in(clk_in), .reset_n(reset_n), .txclk(txclk),
    .req_valid(vld[1]), .req_data0(dat0[1]), .req_data1(dat1[1]),
    .req_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]),
    .owner(owner_o[1]), .tx_done(done_o[1])
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int stop_bits(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [1:0] exp_grant(logic [1:0] v, logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Line level for frame position k: start, data LSB first, then stop bits.
  function automatic logic level(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= D) return b[k-1];
    return 1'b1;
  endfunction

  // ---------------- behavioural model ----------------
  bit       m_busy  [2] = '{1'b0, 1'b0};
  bit       m_tx    [2] = '{1'b1, 1'b1};
  bit       m_owner [2] = '{1'b0, 1'b0};
  bit       m_last  [2] = '{1'b1, 1'b1};
  bit       m_done  [2] = '{1'b0, 1'b0};
  logic [7:0] m_byte [2];
  int       m_tick  [2] = '{0, 0};

  initial begin
    logic [1:0] g;
    forever begin
      @(posedge clk_in or negedge reset_n);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          m_busy[i] = 0; m_tx[i] = 1; m_owner[i] = 0;
          m_last[i] = 1; m_done[i] = 0; m_tick[i] = 0;
        end else begin
          m_done[i] = 0;
          if (!m_busy[i]) begin
            g = exp_grant(vld[i], m_last[i]);
            if (|(vld[i] & g)) begin
              m_busy[i]  = 1;
              m_owner[i] = g[1];
              m_last[i]  = g[1];
              m_byte[i]  = g[1] ? dat1[i] : dat0[i];
              m_tick[i]  = 0;
            end
          end else if (txclk) begin
            if (m_tick[i] < 1 + D + stop_bits(i)) begin
              m_tx[i] = level(m_byte[i], m_tick[i]);
              m_tick[i]++;
            end else begin
              m_busy[i] = 0;
              m_done[i] = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.tx", i), tx_o[i], m_tx[i]);
        chk($sformatf("u%0d.busy", i), busy_o[i], m_busy[i]);
        chk($sformatf("u%0d.owner", i), owner_o[i], m_owner[i]);
        chk($sformatf("u%0d.tx_done", i), done_o[i], m_done[i]);
        chk($sformatf("u%0d.req_ready", i), rdy_o[i],
            m_busy[i] ? 2'b00 : exp_grant(vld[i], m_last[i]));
      end
    end
  end

  // ---------------- frame recorder (tx sampled after each tick) ----------------
  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          len;
    logic        owner;
  } frame_t;

  frame_t      frames[$];
  logic [15:0] tr_bits [2] = '{16'h0, 16'h0};
  int          tr_len  [2] = '{0, 0};
  bit          pend_tick = 0;
  bit          pend_busy [2] = '{1'b0, 1'b0};

  initial begin
    frame_t f;
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          tr_len[i] = 0; tr_bits[i] = '0; pend_busy[i] = 0;
        end else begin
          if (pend_tick && pend_busy[i] && busy_o[i] && tr_len[i] < 16) begin
            tr_bits[i][tr_len[i]] = tx_o[i];
            tr_len[i]++;
          end
          if (done_o[i]) begin
            f.inst = i; f.bits = tr_bits[i]; f.len = tr_len[i]; f.owner = owner_o[i];
            frames.push_back(f);
            tr_len[i] = 0; tr_bits[i] = '0;
          end
          pend_busy[i] = busy_o[i];
        end
      end
      pend_tick = txclk;
    end
  end

  function automatic int count_frames(int inst);
    int n = 0;
    foreach (frames[k]) if (frames[k].inst == inst) n++;
    return n;
  endfunction

  function automatic frame_t nth_frame(int inst, int n);
    frame_t f;
    int c = 0;
    f.inst = inst; f.bits = '0; f.len = -1; f.owner = 1'bx;
    foreach (frames[k]) begin
      if (frames[k].inst == inst) begin
        if (c == n) return frames[k];
        c++;
      end
    end
    return f;
  endfunction

  // ---------------- stimulus helpers ----------------
  int tcnt = 0;
  int tper = 4;

  task automatic step();
    @(posedge clk_in);
    #1;
    if (tcnt >= tper - 1) begin
      txclk = 1'b1;
      tcnt = 0;
    end else begin
      txclk = 1'b0;
      tcnt++;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      vld[i] = 2'b00; dat0[i] = 8'h00; dat1[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    frames.delete();
  endtask

  task automatic wait_frames(int inst, int n, int budget, string name);
    int c = 0;
    while (count_frames(inst) < n && c < budget) begin
      step();
      c++;
    end
    chk(name, count_frames(inst) >= n, 1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    frame_t f;
    int lows;
    int cnt;
    clear_inputs();

    // 1. reset
    reset_n = 1'b0;
    step();
    step();
    @(negedge clk_in);
    chk("rst_tx", tx_o[0], 1);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_ready", rdy_o[0], 2'b00);
    step();
    reset_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      @(negedge clk_in);
      if (tx_o[0] !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", lows, 0);

    // 2. single byte 0xA5: per-tick levels 0,1,0,1,0,0,1,0,1,1 (bit k = tick k)
    do_reset();
    vld[0] = 2'b01; dat0[0] = 8'hA5;
    step();
    vld[0] = 2'b00;
    wait_frames(0, 1, 100, "a5_timeout");
    f = nth_frame(0, 0);
    chk("a5_len", f.len, 10);
    chk("a5_levels", f.bits[9:0], 10'h34A);
    chk("a5_owner", f.owner, 0);
    repeat (20) step();
    chk("a5_done_count", count_frames(0), 1);

    // 3. contention
    do_reset();
    vld[0] = 2'b11; dat0[0] = 8'h11; dat1[0] = 8'h22;
    wait_frames(0, 4, 300, "cont_timeout");
    vld[0] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      f = nth_frame(0, k);
      chk($sformatf("cont_owner%0d", k), f.owner, k % 2);
      chk($sformatf("cont_data%0d", k), f.bits[8:1], (k % 2) ? 8'h22 : 8'h11);
    end

    // 4. handshake in the same cycle as txclk
    do_reset();
    cnt = 0;
    while (txclk !== 1'b1 && cnt < 10) begin
      step();
      cnt++;
    end
    vld[0] = 2'b01; dat0[0] = 8'h0F;
    step();
    vld[0] = 2'b00;
    cnt = 0;
    do begin
      step();
      @(negedge clk_in);
      cnt++;
    end while (tx_o[0] !== 1'b0 && cnt < 50);
    chk("tick_hs_start_latency", cnt, 4);
    wait_frames(0, 1, 100, "tick_hs_timeout");
    f = nth_frame(0, 0);
    chk("tick_hs_data", f.bits[8:1], 8'h0F);

    // 5. reset mid-frame during data bit 3 (0xC3 has bit 3 low)
    do_reset();
    vld[0] = 2'b01; dat0[0] = 8'hC3;
    step();
    vld[0] = 2'b00;
    cnt = 0;
    while (tr_len[0] < 5 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("midrst_reach_bit3", tr_len[0], 5);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tx", tx_o[0], 1);
    chk("midrst_busy", busy_o[0], 0);
    step();
    step();
    reset_n = 1'b1;
    vld[0] = 2'b01; dat0[0] = 8'h3C;
    step();
    vld[0] = 2'b00;
    wait_frames(0, 1, 100, "midrst_timeout");
    f = nth_frame(0, 0);
    chk("midrst_data", f.bits[8:1], 8'h3C);
    chk("midrst_frame_count", count_frames(0), 1);

    // 6. two stop bits with 0xFF: low for 1 tick then high for 10 ticks
    do_reset();
    vld[1] = 2'b01; dat0[1] = 8'hFF;
    step();
    vld[1] = 2'b00;
    wait_frames(1, 1, 120, "stop2_timeout");
    f = nth_frame(1, 0);
    chk("stop2_len", f.len, 11);
    chk("stop2_levels", f.bits[10:0], 11'h7FE);

    // 7. randomized traffic, varying tick period, one async reset
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) tper = $urandom_range(1, 6);
      step();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) vld[i] = 2'($urandom_range(0, 3));
        dat0[i] = 8'($urandom);
        dat1[i] = 8'($urandom);
      end
      if (k == 2000) begin
        #2 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
    end
    chk("rand_frames_u1", count_frames(0) > 10, 1);
    chk("rand_frames_u2", count_frames(1) > 10, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
